// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - memory-strobe bus between controller and responder
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  mem_ready;
  logic                  mem_err;
  logic                  busy;

  modport master (
    output MemRead, MemWrite, addr, write_data,
    input  read_data, mem_ready, mem_err, busy
  );

  modport slave (
    input  MemRead, MemWrite, addr, write_data,
    output read_data, mem_ready, mem_err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated word memory answering controller read/write strobes
module mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  // Counter reload so that WAIT lasts exactly WAIT_CYCLES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  mem_we;
  logic                  in_range;
  logic                  accept;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // State and wait counter; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: accept only in IDLE, count down in WAIT, fixed ACCESS->RESP->IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.MemRead || bus.MemWrite) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and request latches: everything is computed here and registered below.
  always_comb begin
    accept      = (state_q == IDLE) && (bus.MemRead || bus.MemWrite);
    rd_d        = accept ? bus.MemRead    : rd_q;
    wr_d        = accept ? bus.MemWrite   : wr_q;
    addr_d      = accept ? bus.addr       : addr_q;
    wdata_d     = accept ? bus.write_data : wdata_q;
    in_range    = {1'b0, addr_q} < DEPTH_W;
    ready_d     = (state_q == ACCESS);
    err_d       = (state_q == ACCESS) && ((rd_q && wr_q) || !in_range);
    mem_we      = (state_q == ACCESS) && wr_q && !rd_q && in_range;
    read_data_d = read_data_q;
    if ((state_q == ACCESS) && rd_q && !wr_q) begin
      read_data_d = in_range ? mem[addr_q] : '0;
    end
    busy_d      = (state_d != IDLE);
  end

  // Registered outputs and latched request fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // Array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= wdata_q;
  end

  assign bus.read_data = read_data_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_err   = err_q;
  assign bus.busy      = busy_q;

endmodule
